// File: rtl/dmem_loader_pkg.sv
// Shared definitions for the dmem loader: command codes, dsize encodings, FSM states.
package dmem_loader_pkg;

  localparam logic [7:0] LDR_CMD_SET_ADDR = 8'h01;
  localparam logic [7:0] LDR_CMD_WR_WORD  = 8'h02;
  localparam logic [7:0] LDR_CMD_WR_BYTE  = 8'h03;
  localparam logic [7:0] LDR_CMD_DONE     = 8'h04;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StWrite,
    StVerify,
    StFin
  } state_e;

  // Number of bytes covered by an access of the given dsize.
  function automatic logic [2:0] dsize_bytes(input logic [1:0] dsize);
    unique case (dsize)
      DSIZE_WORD: dsize_bytes = 3'd4;
      DSIZE_HALF: dsize_bytes = 3'd2;
      default:    dsize_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_loader_byte_assembler.sv
// MSB-first byte shift register shared by address and data collection.
module dmem_loader_byte_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  in_data,
  input  logic [1:0]  last_idx,
  output logic [31:0] value,
  output logic        count_reached
);

  logic [31:0] value_q;
  logic [1:0]  count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      count_q <= '0;
    end else if (clr) begin
      value_q <= '0;
      count_q <= '0;
    end else if (shift_en) begin
      value_q <= {value_q[23:0], in_data};
      count_q <= count_q + 2'd1;
    end
  end

  assign value         = value_q;
  // High while the byte being presented now is the last one of the field.
  assign count_reached = (count_q == last_idx);

endmodule

// File: rtl/dmem_loader.sv
// Streams host bytes into dmem writes and holds the CPU until DONE.
// Optional readback verify of each write: define LOADER_READBACK_EN.
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned ADDR_LIMIT = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [1:0]  mem_dsize,
  input  logic [31:0] mem_rdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] wr_count
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  dsize_q, dsize_d;

  logic        asm_clr, asm_shift, asm_last;
  logic [1:0]  asm_last_idx;
  logic [31:0] asm_value;
  logic [32:0] end_addr;
  logic        in_range;
  logic [31:0] addr_inc;
  logic        rb_mismatch;

  assign asm_last_idx = (state_q == StAddr || dsize_q == DSIZE_WORD) ? 2'd3 : 2'd0;

  dmem_loader_byte_assembler u_asm (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (asm_clr),
    .shift_en      (asm_shift),
    .in_data       (in_data),
    .last_idx      (asm_last_idx),
    .value         (asm_value),
    .count_reached (asm_last)
  );

  // 33-bit sum so an access wrapping past 2^32 still counts as out of range.
  assign end_addr = {1'b0, addr_q} + {30'b0, dsize_bytes(dsize_q)};
  assign in_range = (end_addr <= 33'(ADDR_LIMIT));
  assign addr_inc = addr_q + {29'b0, dsize_bytes(dsize_q)};

`ifdef LOADER_READBACK_EN
  assign rb_mismatch = (dsize_q == DSIZE_WORD) ? (mem_rdata != asm_value)
                                               : (mem_rdata[7:0] != asm_value[7:0]);
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign rb_mismatch  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    dsize_d   = dsize_q;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    asm_clr   = 1'b0;
    asm_shift = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        asm_clr  = 1'b1;
        if (in_valid) begin
          case (in_data)
            LDR_CMD_SET_ADDR: state_d = StAddr;
            LDR_CMD_WR_WORD: begin
              dsize_d = DSIZE_WORD;
              state_d = StData;
            end
            LDR_CMD_WR_BYTE: begin
              dsize_d = DSIZE_BYTE;
              state_d = StData;
            end
            LDR_CMD_DONE:     state_d = StFin;
            default:          err_d   = 1'b1;
          endcase
        end
      end
      StAddr: begin
        in_ready  = 1'b1;
        asm_shift = in_valid;
        if (in_valid && asm_last) begin
          addr_d  = {asm_value[23:0], in_data};
          state_d = StIdle;
        end
      end
      StData: begin
        in_ready  = 1'b1;
        asm_shift = in_valid;
        if (in_valid && asm_last) state_d = StWrite;
      end
      StWrite: begin
        if (in_range) begin
          mem_we = 1'b1;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`ifdef LOADER_READBACK_EN
          // Address advances after the verify so the readback sees the written location.
          state_d = StVerify;
`else
          addr_d  = addr_inc;
          state_d = StIdle;
`endif
        end else begin
          err_d   = 1'b1;
          addr_d  = addr_inc;
          state_d = StIdle;
        end
      end
`ifdef LOADER_READBACK_EN
      StVerify: begin
        if (rb_mismatch) err_d = 1'b1;
        addr_d  = addr_inc;
        state_d = StIdle;
      end
`endif
      StFin: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      dsize_q <= DSIZE_WORD;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      dsize_q <= dsize_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = asm_value;
  assign mem_dsize = dsize_q;
  assign done      = (state_q == StFin);
  assign cpu_hold  = ~done;
  assign err       = err_q;
  assign wr_count  = cnt_q;

endmodule

// File: tb/tb_dmem_loader.sv
// Directed self-checking bench for dmem_loader (default build; readback test when
// LOADER_READBACK_EN is defined).
module tb_dmem_loader;

`ifdef LOADER_READBACK_EN
  localparam int WrLat = 2;
`else
  localparam int WrLat = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [1:0]  mem_dsize;
  logic        cpu_hold, done, err;
  logic [15:0] wr_count;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  logic [31:0] dmem_last = 32'h0;

  always #5 clk = ~clk;

  dmem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_dsize (mem_dsize),
    .mem_rdata (mem_rdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .wr_count  (wr_count)
  );

  // Tiny dmem model: remembers the last write; reads of 0x10 come back corrupted.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_cnt    <= we_cnt + 1;
      dmem_last <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_addr == 32'h10) ? ~dmem_last : dmem_last;

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents one byte; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
    end
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send5(input logic [7:0] c, input logic [31:0] v);
    send_byte(c);
    send_byte(v[31:24]);
    send_byte(v[23:16]);
    send_byte(v[15:8]);
    send_byte(v[7:0]);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", mem_we); end
    tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    tests++; if (mem_dsize !== 2'b10) begin fails++; $display("FAIL rst_dsize: got %b want 10", mem_dsize); end
    tests++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL rst_hold_done: got %b%b want 10", cpu_hold, done); end
    tests++; if (err !== 1'b0 || wr_count !== 16'h0) begin fails++; $display("FAIL rst_err_cnt: got %b %h want 0 0000", err, wr_count); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 00000000", mem_addr); end
  endtask

  task automatic test_word();
    int w0 = we_cnt;
    send5(8'h01, 32'h0000_2000);
    tests++; if (mem_addr !== 32'h2000) begin fails++; $display("FAIL set_addr: got %h want 00002000", mem_addr); end
    send5(8'h02, 32'hDEAD_BEEF);
    tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL word_we: got %b want 1", mem_we); end
    tests++; if (mem_addr !== 32'h2000 || mem_wdata !== 32'hDEAD_BEEF || mem_dsize !== 2'b10) begin
      fails++; $display("FAIL word_bus: got %h %h %b want 00002000 deadbeef 10", mem_addr, mem_wdata, mem_dsize);
    end
    repeat (WrLat) @(posedge clk);
    #1;
    tests++; if (wr_count !== 16'd1 || we_cnt - w0 != 1) begin fails++; $display("FAIL word_count: got %0d/%0d want 1/1", wr_count, we_cnt - w0); end
    tests++; if (mem_addr !== 32'h2004 || in_ready !== 1'b1) begin fails++; $display("FAIL word_next: got %h %b want 00002004 1", mem_addr, in_ready); end
  endtask

  task automatic test_byte();
    send_byte(8'h03);
    send_byte(8'h5A);
    tests++; if (mem_we !== 1'b1 || mem_addr !== 32'h2004) begin fails++; $display("FAIL byte_we: got %b %h want 1 00002004", mem_we, mem_addr); end
    tests++; if (mem_wdata[7:0] !== 8'h5A || mem_dsize !== 2'b00) begin fails++; $display("FAIL byte_bus: got %h %b want 5a 00", mem_wdata[7:0], mem_dsize); end
    repeat (WrLat) @(posedge clk);
    #1;
    tests++; if (mem_addr !== 32'h2005 || wr_count !== 16'd2) begin fails++; $display("FAIL byte_next: got %h %0d want 00002005 2", mem_addr, wr_count); end
  endtask

  task automatic test_out_of_range();
    int w0 = we_cnt;
    send5(8'h01, 32'h0000_3FFE);
    send5(8'h02, 32'h1122_3344);
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL oor_we: got %b want 0", mem_we); end
    @(posedge clk);
    #1;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL oor_err: got %b want 1", err); end
    tests++; if (mem_addr !== 32'h4002) begin fails++; $display("FAIL oor_addr: got %h want 00004002", mem_addr); end
    tests++; if (wr_count !== 16'd2 || we_cnt != w0) begin fails++; $display("FAIL oor_count: got %0d/%0d want 2/0", wr_count, we_cnt - w0); end
  endtask

  task automatic test_reset_mid_frame();
    int w0 = we_cnt;
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_wdata !== 32'h0 || mem_dsize !== 2'b10) begin
      fails++; $display("FAIL mid_rst_bus: got %b %b %h %b want 1 0 00000000 10", in_ready, mem_we, mem_wdata, mem_dsize);
    end
    tests++; if (err !== 1'b0 || wr_count !== 16'h0 || mem_addr !== 32'h0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL mid_rst_state: got %b %h %h %b %b want 0 0000 00000000 1 0", err, wr_count, mem_addr, cpu_hold, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (we_cnt != w0) begin fails++; $display("FAIL mid_rst_nowrite: got %0d writes want 0", we_cnt - w0); end
    send5(8'h01, 32'h0000_0040);
    send5(8'h02, 32'hCAFE_BABE);
    tests++; if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hCAFE_BABE) begin
      fails++; $display("FAIL mid_rst_frame: got %b %h %h want 1 00000040 cafebabe", mem_we, mem_addr, mem_wdata);
    end
    repeat (WrLat) @(posedge clk);
    #1;
    tests++; if (wr_count !== 16'd1 || err !== 1'b0) begin fails++; $display("FAIL mid_rst_count: got %0d %b want 1 0", wr_count, err); end
  endtask

`ifdef LOADER_READBACK_EN
  task automatic test_readback();
    do_reset();
    send5(8'h01, 32'h0000_0020);
    send5(8'h02, 32'h1234_5678);
    repeat (2) @(posedge clk);
    #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rb_match: got %b want 0", err); end
    send5(8'h01, 32'h0000_0010);
    send5(8'h02, 32'h1234_5678);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rb_pre: got %b want 0", err); end
    @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b0 || mem_addr !== 32'h10) begin fails++; $display("FAIL rb_verify: got %b %h want 0 00000010", in_ready, mem_addr); end
    @(posedge clk);
    #1;
    tests++; if (err !== 1'b1 || mem_addr !== 32'h14) begin fails++; $display("FAIL rb_mismatch: got %b %h want 1 00000014", err, mem_addr); end
  endtask
`endif

  task automatic test_unknown_and_done();
    int w0;
    do_reset();
    send5(8'h01, 32'h0000_0100);
    send_byte(8'h7F);
    tests++; if (err !== 1'b1 || in_ready !== 1'b1) begin fails++; $display("FAIL unk_err: got %b %b want 1 1", err, in_ready); end
    send_byte(8'h04);
    tests++; if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL done_state: got %b %b %b want 1 0 0", done, cpu_hold, in_ready);
    end
    w0 = we_cnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h03;
    repeat (3) @(negedge clk);
    in_data = 8'h5A;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    tests++; if (we_cnt != w0 || wr_count !== 16'd0) begin fails++; $display("FAIL done_ignore: got %0d %0d want 0 0", we_cnt - w0, wr_count); end
    tests++; if (done !== 1'b1 || in_ready !== 1'b0 || mem_addr !== 32'h100) begin
      fails++; $display("FAIL done_terminal: got %b %b %h want 1 0 00000100", done, in_ready, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_out_of_range();
    test_reset_mid_frame();
`ifdef LOADER_READBACK_EN
    test_readback();
`endif
    test_unknown_and_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
